// File: rtl/mem_sys_pkg.sv
// Shared definitions for the memory port arbiter: default region bases,
// FSM state encoding and requester (owner) encoding.
package mem_sys_pkg;

    localparam int          MEMORY_DEPTH_DEF = 32;
    localparam logic [31:0] ROM_BASE_DEF     = 32'h0040_0000;
    localparam logic [31:0] RAM_BASE_DEF     = 32'h1001_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address check: classifies a byte address into ROM / RAM
// regions and flags misaligned, unmapped, or ROM-write accesses.
module mem_addr_decode #(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] ROM_BASE     = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] RAM_BASE     = 32'h1001_0000
) (
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic                  write,
    output logic                  in_rom,
    output logic                  in_ram,
    output logic                  err
);

    // Byte span of each region; regions do not wrap.
    localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(4 * MEMORY_DEPTH);

    // Region membership uses an offset compare so the top word is legal
    // and the word just past it is not.
    always_comb begin
        in_rom = (addr >= ROM_BASE) && ((addr - ROM_BASE) < SPAN);
        in_ram = (addr >= RAM_BASE) && ((addr - RAM_BASE) < SPAN);
        err    = (addr[1:0] != 2'b00) || !(in_rom || in_ram) || (write && in_rom);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory wrapper port between instruction
// fetch (read-only) and data memory (read/write). Each transaction runs
// IDLE -> ACCESS -> RESP, with a one-cycle ack in RESP.
module mem_port_arbiter
    import mem_sys_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = MEMORY_DEPTH_DEF,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] ROM_BASE     = ROM_BASE_DEF,
    parameter logic [DATA_WIDTH-1:0] RAM_BASE     = RAM_BASE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  IF_Req_i,
    input  logic [DATA_WIDTH-1:0] IF_Address_i,
    output logic                  IF_Ack_o,
    output logic [DATA_WIDTH-1:0] IF_Data_o,
    output logic                  IF_Err_o,

    input  logic                  DM_Req_i,
    input  logic                  DM_Write_i,
    input  logic [DATA_WIDTH-1:0] DM_Address_i,
    input  logic [DATA_WIDTH-1:0] DM_Write_Data_i,
    output logic                  DM_Ack_o,
    output logic [DATA_WIDTH-1:0] DM_Data_o,
    output logic                  DM_Err_o,

    output logic [DATA_WIDTH-1:0] Mem_Address_o,
    output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
    output logic                  Mem_Write_Enable_o,
    input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i,

    output logic                  Busy_o
);

    state_t                state, state_nxt;
    owner_t                last_grant, owner_q, win;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q, data_q;
    logic [DATA_WIDTH-1:0] sel_addr;
    logic                  sel_write;
    logic                  write_q, err_q;
    logic                  any_req;
    logic                  dec_in_rom, dec_in_ram, dec_err;
    logic                  unused_region;

    assign any_req = IF_Req_i || DM_Req_i;

    // Pick the winner and mux its request; on a tie, the side not granted last wins.
    always_comb begin
        win = OWN_IF;
        if (IF_Req_i && DM_Req_i)
            win = (last_grant == OWN_DM) ? OWN_IF : OWN_DM;
        else if (DM_Req_i)
            win = OWN_DM;
        sel_addr  = (win == OWN_DM) ? DM_Address_i : IF_Address_i;
        sel_write = (win == OWN_DM) && DM_Write_i;
    end

    mem_addr_decode #(
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .ROM_BASE     (ROM_BASE),
        .RAM_BASE     (RAM_BASE)
    ) u_decode (
        .addr   (sel_addr),
        .write  (sel_write),
        .in_rom (dec_in_rom),
        .in_ram (dec_in_ram),
        .err    (dec_err)
    );

    // Region flags are folded into the error; kept as nets for debug probing.
    assign unused_region = dec_in_rom | dec_in_ram;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: requests are only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the granted request in IDLE and capture read data at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= OWN_DM;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                last_grant <= win;
                owner_q    <= win;
                addr_q     <= sel_addr;
                wdata_q    <= DM_Write_Data_i;
                write_q    <= sel_write;
                err_q      <= dec_err;
            end
            if (state == ACCESS)
                data_q <= err_q ? '0 : Mem_Read_Data_i;
        end
    end

    // Memory side: address/data hold last latched value; write only in ACCESS,
    // and never while reset is asserted so an aborted store cannot land.
    always_comb begin
        Mem_Address_o      = addr_q;
        Mem_Write_Data_o   = wdata_q;
        Mem_Write_Enable_o = (state == ACCESS) && write_q && !err_q && reset;
    end

    // Requester side: only the owner sees ack/data/err, and only in RESP.
    always_comb begin
        IF_Ack_o  = (state == RESP) && (owner_q == OWN_IF);
        DM_Ack_o  = (state == RESP) && (owner_q == OWN_DM);
        IF_Err_o  = IF_Ack_o && err_q;
        DM_Err_o  = DM_Ack_o && err_q;
        IF_Data_o = IF_Ack_o ? data_q : '0;
        DM_Data_o = DM_Ack_o ? data_q : '0;
        Busy_o    = (state != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural ROM/RAM wrapper model.
module tb_mem_port_arbiter;

    localparam logic [31:0] ROM_B = 32'h0040_0000;
    localparam logic [31:0] RAM_B = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        IF_Req_i, DM_Req_i, DM_Write_i;
    logic [31:0] IF_Address_i, DM_Address_i, DM_Write_Data_i;
    logic        IF_Ack_o, IF_Err_o, DM_Ack_o, DM_Err_o;
    logic [31:0] IF_Data_o, DM_Data_o;
    logic [31:0] Mem_Address_o, Mem_Write_Data_o, Mem_Read_Data_i;
    logic        Mem_Write_Enable_o, Busy_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk                (clk),
        .reset              (reset),
        .IF_Req_i           (IF_Req_i),
        .IF_Address_i       (IF_Address_i),
        .IF_Ack_o           (IF_Ack_o),
        .IF_Data_o          (IF_Data_o),
        .IF_Err_o           (IF_Err_o),
        .DM_Req_i           (DM_Req_i),
        .DM_Write_i         (DM_Write_i),
        .DM_Address_i       (DM_Address_i),
        .DM_Write_Data_i    (DM_Write_Data_i),
        .DM_Ack_o           (DM_Ack_o),
        .DM_Data_o          (DM_Data_o),
        .DM_Err_o           (DM_Err_o),
        .Mem_Address_o      (Mem_Address_o),
        .Mem_Write_Data_o   (Mem_Write_Data_o),
        .Mem_Write_Enable_o (Mem_Write_Enable_o),
        .Mem_Read_Data_i    (Mem_Read_Data_i),
        .Busy_o             (Busy_o)
    );

    // Wrapper model: fixed ROM pattern, writable RAM, combinational read.
    function automatic logic [31:0] rom_word(input int i);
        return 32'hC0DE_0000 + i;
    endfunction

    logic [31:0] ram [32];
    logic        mem_init = 1'b1;
    logic        rom_written = 1'b0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) ram[i] <= 32'h5A5A_0000 + i;
        end else if (Mem_Write_Enable_o) begin
            if (Mem_Address_o >= RAM_B && Mem_Address_o < RAM_B + 128)
                ram[(Mem_Address_o - RAM_B) >> 2] <= Mem_Write_Data_o;
            else
                rom_written <= 1'b1;
        end
    end

    always_comb begin
        Mem_Read_Data_i = 32'hDEAD_BEEF;
        if (Mem_Address_o >= ROM_B && Mem_Address_o < ROM_B + 128)
            Mem_Read_Data_i = rom_word(int'((Mem_Address_o - ROM_B) >> 2));
        else if (Mem_Address_o >= RAM_B && Mem_Address_o < RAM_B + 128)
            Mem_Read_Data_i = ram[(Mem_Address_o - RAM_B) >> 2];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        is_dm;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        chk_data;
    } vec_t;

    vec_t vecs [14];

    // One single-requester transaction: ACCESS, RESP, back to IDLE.
    task automatic do_txn(input vec_t v, input string tag);
        IF_Req_i        = !v.is_dm;
        DM_Req_i        = v.is_dm;
        IF_Address_i    = v.addr;
        DM_Address_i    = v.addr;
        DM_Write_i      = v.wr;
        DM_Write_Data_i = v.wdata;
        tick();
        chk({tag, "_busy"}, 32'(Busy_o), 32'd1);
        chk({tag, "_maddr"}, Mem_Address_o, v.addr);
        chk({tag, "_we_access"}, 32'(Mem_Write_Enable_o), 32'(v.wr && !v.exp_err));
        chk({tag, "_early_ack"}, 32'(IF_Ack_o | DM_Ack_o), 32'd0);
        tick();
        chk({tag, "_ack"}, {30'd0, DM_Ack_o, IF_Ack_o}, v.is_dm ? 32'd2 : 32'd1);
        chk({tag, "_err"}, 32'(v.is_dm ? DM_Err_o : IF_Err_o), 32'(v.exp_err));
        if (v.chk_data)
            chk({tag, "_data"}, v.is_dm ? DM_Data_o : IF_Data_o, v.exp_data);
        chk({tag, "_we_resp"}, 32'(Mem_Write_Enable_o), 32'd0);
        IF_Req_i = 1'b0;
        DM_Req_i = 1'b0;
        tick();
        chk({tag, "_idle"}, 32'(Busy_o | IF_Ack_o | DM_Ack_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nacks;
        int last_c;
        logic exp_dm;

        vecs[0]  = '{1'b0, 1'b0, 32'h0040_0004, 32'h0,         32'hC0DE_0001, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 32'h1001_0008, 32'h1234_5678, 32'h0,         1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h1001_0008, 32'h0,         32'h1234_5678, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 32'h1001_0008, 32'h0,         32'h1234_5678, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0040_007C, 32'h0,         32'hC0DE_001F, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h0040_0080, 32'h0,         32'h0,         1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 32'h0040_0000, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 32'h1001_0002, 32'h0,         32'h0,         1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h1001_0080, 32'h0,         32'h0,         1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 32'h0040_0000, 32'h0,         32'hC0DE_0000, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'h1001_007C, 32'h0,         32'h5A5A_001F, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 32'h1001_007C, 32'hFFFF_0000, 32'h0,         1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h1001_007C, 32'h0,         32'hFFFF_0000, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 32'h003F_FFFC, 32'h0,         32'h0,         1'b1, 1'b1};

        // Reset held with both requesters asking.
        reset           = 1'b0;
        IF_Req_i        = 1'b1;
        IF_Address_i    = 32'h0040_0008;
        DM_Req_i        = 1'b1;
        DM_Write_i      = 1'b0;
        DM_Address_i    = 32'h1001_0004;
        DM_Write_Data_i = 32'h0;
        tick();
        mem_init = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_busy", 32'(Busy_o), 32'd0);
            chk("rst_ack", 32'(IF_Ack_o | DM_Ack_o), 32'd0);
            chk("rst_we", 32'(Mem_Write_Enable_o), 32'd0);
        end
        chk("rst_maddr", Mem_Address_o, 32'h0);

        // Both requests held: IF first, then alternate, acks 3 cycles apart.
        reset  = 1'b1;
        nacks  = 0;
        last_c = 0;
        for (int c = 1; c <= 30 && nacks < 4; c++) begin
            tick();
            if (IF_Ack_o || DM_Ack_o) begin
                exp_dm = nacks[0];
                chk("alt_owner", {30'd0, DM_Ack_o, IF_Ack_o}, exp_dm ? 32'd2 : 32'd1);
                chk("alt_data", exp_dm ? DM_Data_o : IF_Data_o,
                    exp_dm ? 32'h5A5A_0001 : rom_word(2));
                chk("alt_gap", 32'(c - last_c), (nacks == 0) ? 32'd2 : 32'd3);
                last_c = c;
                nacks++;
            end
        end
        checks++;
        if (nacks != 4) begin
            errors++;
            $display("FAIL alt_count: got %0d acks expected 4", nacks);
        end
        IF_Req_i = 1'b0;
        DM_Req_i = 1'b0;
        tick();
        tick();
        chk("alt_idle", 32'(Busy_o), 32'd0);

        // Table of single-requester transactions.
        for (int i = 0; i < 14; i++)
            do_txn(vecs[i], $sformatf("v%0d", i));

        // Reset dropped during ACCESS of a store: no write, no ack.
        DM_Req_i        = 1'b1;
        DM_Write_i      = 1'b1;
        DM_Address_i    = 32'h1001_000C;
        DM_Write_Data_i = 32'hBAD0_BAD0;
        tick();
        chk("abort_we_before", 32'(Mem_Write_Enable_o), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_we_gated", 32'(Mem_Write_Enable_o), 32'd0);
        tick();
        DM_Req_i = 1'b0;
        chk("abort_busy", 32'(Busy_o), 32'd0);
        chk("abort_ack", 32'(IF_Ack_o | DM_Ack_o), 32'd0);
        chk("abort_maddr", Mem_Address_o, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        chk("abort_ack_later", 32'(IF_Ack_o | DM_Ack_o), 32'd0);
        chk("abort_ram_kept", ram[3], 32'h5A5A_0003);
        do_txn('{1'b1, 1'b0, 32'h1001_000C, 32'h0, 32'h5A5A_0003, 1'b0, 1'b1}, "abort_reload");

        chk("rom_never_written", 32'(rom_written), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
